// File: rtl/led_pattern_driver_if.sv
// LED pattern driver bus: the step strobe and switch bank in, three colour banks out.
// The count stage side (or a bench) uses the master modport and the pattern driver
// uses the slave modport.
interface led_pattern_driver_if #(
    parameter int N_LEDS = 5
);
    logic              valid;
    logic [3:0]        sw;
    logic [N_LEDS-1:0] led;
    logic [N_LEDS-1:0] led_b;
    logic [N_LEDS-1:0] led_g;

    modport master (
        output valid,
        output sw,
        input  led,
        input  led_b,
        input  led_g
    );

    modport slave (
        input  valid,
        input  sw,
        output led,
        output led_b,
        output led_g
    );
endinterface

// File: rtl/led_pattern_driver.sv
// LED pattern driver.
// Advances a one-hot (or blink) LED pattern once per step strobe from the count stage.
// sw[1:0] selects the pattern mode and sw[3:2] selects which colour bank shows it.
// A mode change is only acted on at a step strobe. That step loads the mode's seed
// pattern instead of advancing.
module led_pattern_driver #(
    parameter int N_LEDS = 5
) (
    input  logic               clock,
    input  logic               reset_n,
    led_pattern_driver_if.slave bus
);

    typedef enum logic [2:0] {
        SHL    = 3'd0,
        SHR    = 3'd1,
        PP_UP  = 3'd2,
        PP_DN  = 3'd3,
        BL_ON  = 3'd4,
        BL_OFF = 3'd5
    } state_t;

    localparam logic [1:0] MODE_SHL   = 2'b00;
    localparam logic [1:0] MODE_SHR   = 2'b01;
    localparam logic [1:0] MODE_PING  = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    localparam logic [N_LEDS-1:0] SEED_LSB = {{(N_LEDS-1){1'b0}}, 1'b1};
    localparam logic [N_LEDS-1:0] SEED_MSB = {1'b1, {(N_LEDS-1){1'b0}}};

    state_t            state;
    state_t            next_state;
    logic [N_LEDS-1:0] pattern;
    logic [N_LEDS-1:0] next_pattern;
    logic [1:0]        mode_q;
    logic [1:0]        next_mode;
    logic [N_LEDS-1:0] next_led;
    logic [N_LEDS-1:0] next_led_b;
    logic [N_LEDS-1:0] next_led_g;

    // Decide the next state and pattern: hold without a strobe, reseed on a mode change, otherwise step.
    always_comb begin
        next_state   = state;
        next_pattern = pattern;
        next_mode    = mode_q;
        if (bus.valid) begin
            next_mode = bus.sw[1:0];
            if (bus.sw[1:0] != mode_q) begin
                case (bus.sw[1:0])
                    MODE_SHL: begin
                        next_state   = SHL;
                        next_pattern = SEED_LSB;
                    end
                    MODE_SHR: begin
                        next_state   = SHR;
                        next_pattern = SEED_MSB;
                    end
                    MODE_PING: begin
                        next_state   = PP_UP;
                        next_pattern = SEED_LSB;
                    end
                    MODE_BLINK: begin
                        next_state   = BL_ON;
                        next_pattern = '1;
                    end
                    default: begin
                        next_state   = SHL;
                        next_pattern = SEED_LSB;
                    end
                endcase
            end else begin
                case (state)
                    SHL: begin
                        next_pattern = {pattern[N_LEDS-2:0], pattern[N_LEDS-1]};
                    end
                    SHR: begin
                        next_pattern = {pattern[0], pattern[N_LEDS-1:1]};
                    end
                    PP_UP: begin
                        // Turn around on the step that lands on the MSB so the end is shown only once.
                        next_pattern = pattern << 1;
                        if (pattern[N_LEDS-2]) begin
                            next_state = PP_DN;
                        end
                    end
                    PP_DN: begin
                        next_pattern = pattern >> 1;
                        if (pattern[1]) begin
                            next_state = PP_UP;
                        end
                    end
                    BL_ON: begin
                        next_state   = BL_OFF;
                        next_pattern = '0;
                    end
                    BL_OFF: begin
                        next_state   = BL_ON;
                        next_pattern = '1;
                    end
                    default: begin
                        next_state   = SHL;
                        next_pattern = SEED_LSB;
                    end
                endcase
            end
        end
    end

    // Route the upcoming pattern onto the colour bank(s) picked by sw[3:2]; 11 drives all banks (white).
    always_comb begin
        next_led   = '0;
        next_led_b = '0;
        next_led_g = '0;
        case (bus.sw[3:2])
            2'b00: next_led   = next_pattern;
            2'b01: next_led_b = next_pattern;
            2'b10: next_led_g = next_pattern;
            default: begin
                next_led   = next_pattern;
                next_led_b = next_pattern;
                next_led_g = next_pattern;
            end
        endcase
    end

    // Register the FSM, the pattern, the mode seen at the last step and the three LED banks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SHL;
            pattern   <= SEED_LSB;
            mode_q    <= MODE_SHL;
            bus.led   <= '0;
            bus.led_b <= '0;
            bus.led_g <= '0;
        end else begin
            state     <= next_state;
            pattern   <= next_pattern;
            mode_q    <= next_mode;
            bus.led   <= next_led;
            bus.led_b <= next_led_b;
            bus.led_g <= next_led_g;
        end
    end

endmodule
